alu_issue_stage: RTL and testbench

//  Upstream feeder for ArithmeticLogicUnit. Buffers ALU ops {A,B,FunSel,WF} from the control

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_op_fifo.sv | 61 ++++++
 rtl/alu_issue_stage.sv | 151 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU function-select codes,
// flag bit positions, issue FSM encoding and the op-word width helper.
package alu_pkg;

   localparam logic [4:0] FS_AND8   = 5'b00111;
   localparam logic [4:0] FS_AND16  = 5'b10111;
   localparam logic [4:0] FS_OR16   = 5'b11000;
   localparam logic [4:0] FS_XOR16  = 5'b11001;
   localparam logic [4:0] FS_NAND16 = 5'b11010;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ISSUE   = 2'b01,
      ST_CAPTURE = 2'b10,
      ST_HOLD    = 2'b11
   } state_t;

   // Packed op word is {A, B, FunSel[4:0], WF}.
   function automatic int op_width(input int width);
      return 2 * width + 6;
   endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Synchronous DEPTH-entry op FIFO with push/pop/full/empty; pushes while full
// and pops while empty are ignored. DEPTH must be a power of two.
module alu_op_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 38
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign full      = (count_r == FULL_COUNT);
   assign empty     = (count_r == '0);
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign rdata     = mem_r[rd_ptr_r];

   // pointer and occupancy state; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // storage array write port
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Buffers ALU ops and issues them one at a time, capturing result then flags.
// Optional macro ALU_ISSUE_PERF_EN adds IssueCount/StallCount outputs.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] InA,
   input  logic [WIDTH-1:0] InB,
   input  logic [4:0]       InFunSel,
   input  logic             InWF,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [4:0]       FunSel,
   output logic             WF,
   input  logic [WIDTH-1:0] ALUOut,
   input  logic [3:0]       FlagsOut,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutResult,
   output logic [3:0]       OutFlags
`ifdef ALU_ISSUE_PERF_EN
   ,
   output logic [15:0]      IssueCount,
   output logic [15:0]      StallCount
`endif
);

   localparam int OPW = op_width(WIDTH);

   state_t           state_r;
   state_t           state_s;
   logic             fifo_push_s;
   logic             fifo_pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [OPW-1:0]   fifo_wdata_s;
   logic [OPW-1:0]   fifo_rdata_s;

   assign fifo_push_s  = InValid & ~fifo_full_s;
   assign fifo_wdata_s = {InA, InB, InFunSel, InWF};
   assign InReady      = ~fifo_full_s;

   alu_op_fifo #(
      .DEPTH (DEPTH),
      .DW    (OPW)
   ) u_fifo (
      .clk   (Clock),
      .rst   (Reset),
      .push  (fifo_push_s),
      .pop   (fifo_pop_s),
      .wdata (fifo_wdata_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // next state and FIFO pop; an op is popped on the edge that enters ISSUE
   always_comb begin
      state_s    = state_r;
      fifo_pop_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) begin
               fifo_pop_s = 1'b1;
               state_s    = ST_ISSUE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE:   state_s = ST_CAPTURE;
         ST_CAPTURE: state_s = ST_HOLD;
         ST_HOLD: begin
            if (OutReady) begin
               if (!fifo_empty_s) begin
                  fifo_pop_s = 1'b1;
                  state_s    = ST_ISSUE;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // ALU drive and downstream capture; WF is set only on the pop edge so it lasts one cycle
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         A         <= '0;
         B         <= '0;
         FunSel    <= 5'b00000;
         WF        <= 1'b0;
         OutValid  <= 1'b0;
         OutResult <= '0;
         OutFlags  <= 4'b0000;
      end else begin
         if (fifo_pop_s) begin
            A      <= fifo_rdata_s[OPW-1 -: WIDTH];
            B      <= fifo_rdata_s[WIDTH+5 -: WIDTH];
            FunSel <= fifo_rdata_s[5:1];
            WF     <= fifo_rdata_s[0];
         end else begin
            WF <= 1'b0;
         end
         if (state_r == ST_ISSUE) begin
            OutResult <= ALUOut;
         end
         if (state_r == ST_CAPTURE) begin
            OutFlags <= FlagsOut;
            OutValid <= 1'b1;
         end else if ((state_r == ST_HOLD) && OutReady) begin
            OutValid <= 1'b0;
         end
      end
   end

`ifdef ALU_ISSUE_PERF_EN
   // issue and downstream-stall event counters, free-running with wrap
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         IssueCount <= 16'h0000;
         StallCount <= 16'h0000;
      end else begin
         if (state_r == ST_ISSUE) begin
            IssueCount <= IssueCount + 16'd1;
         end
         if ((state_r == ST_HOLD) && !OutReady) begin
            StallCount <= StallCount + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU behind it and a queue-based
// reference model of expected results/flags in issue order.
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [15:0] InA, InB;
   logic [4:0]  InFunSel;
   logic        InWF;
   logic [15:0] A, B;
   logic [4:0]  FunSel;
   logic        WF;
   logic [15:0] alu_out;
   logic [3:0]  alu_flags;
   logic        OutValid;
   logic        OutReady;
   logic [15:0] OutResult;
   logic [3:0]  OutFlags;
`ifdef ALU_ISSUE_PERF_EN
   logic [15:0] IssueCount, StallCount;
`endif

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  flags;
      logic        wf;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  model_flags;
   logic [3:0]  flags_before;
   logic        preset_en;
   logic [3:0]  preset_val;
   int          errors = 0;
   int          checks = 0;
   int          beats = 0;
   int          stalls = 0;
   int          wf_cycles = 0;
   int          wf_done = 0;
   logic        wf_prev = 1'b0;
   logic [15:0] ra, rb;
   logic [4:0]  rfs;
   logic        rwf;
   logic [4:0]  fs_tab [5] = '{FS_AND16, FS_OR16, FS_XOR16, FS_NAND16, FS_AND8};

   always #5 Clock = ~Clock;

   alu_issue_stage #(.DEPTH(4), .WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .InA(InA), .InB(InB), .InFunSel(InFunSel), .InWF(InWF),
      .A(A), .B(B), .FunSel(FunSel), .WF(WF),
      .ALUOut(alu_out), .FlagsOut(alu_flags),
      .OutValid(OutValid), .OutReady(OutReady),
      .OutResult(OutResult), .OutFlags(OutFlags)
`ifdef ALU_ISSUE_PERF_EN
      , .IssueCount(IssueCount), .StallCount(StallCount)
`endif
   );

   function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [4:0] fs);
      case (fs)
         FS_AND16:  return a & b;
         FS_OR16:   return a | b;
         FS_XOR16:  return a ^ b;
         FS_NAND16: return ~(a & b);
         FS_AND8:   return {8'h00, a[7:0] & b[7:0]};
         default:   return 16'h0000;
      endcase
   endfunction

   // logic ops update Z and N only; C and O are kept
   function automatic logic [3:0] flag_fn(input logic [15:0] r, input logic [4:0] fs, input logic [3:0] old);
      logic [3:0] f;
      f = old;
      if (fs == FS_AND8) begin
         f[FLAG_Z] = (r[7:0] == 8'h00);
         f[FLAG_N] = r[7];
      end else begin
         f[FLAG_Z] = (r == 16'h0000);
         f[FLAG_N] = r[15];
      end
      return f;
   endfunction

   // behavioural ALU: combinational result, flags registered on WF
   always_comb alu_out = alu_fn(A, B, FunSel);

   always @(posedge Clock) begin
      if (preset_en) alu_flags <= preset_val;
      else if (WF) alu_flags <= flag_fn(alu_out, FunSel, alu_flags);
   end

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // downstream monitor: scoreboard compare at each accepted beat
   always @(negedge Clock) begin
      if (Reset) begin
         beats   = 0;
         stalls  = 0;
         wf_prev = 1'b0;
      end else begin
         if (WF === 1'b1) begin
            wf_cycles++;
            check({31'b0, wf_prev}, 32'd0, "wf_one_edge");
         end
         wf_prev = (WF === 1'b1);
         if (OutValid === 1'b1 && OutReady === 1'b0) stalls++;
         if (OutValid === 1'b1 && OutReady === 1'b1) begin
            check(32'(exp_q.size() != 0), 32'd1, "beat_expected");
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check({16'b0, OutResult}, {16'b0, e.res}, "result");
               check({28'b0, OutFlags}, {28'b0, e.flags}, "flags");
               if (e.wf) wf_done++;
               beats++;
            end
         end
      end
   end

   task automatic preset(input logic [3:0] v);
      preset_val  = v;
      preset_en   = 1'b1;
      step();
      preset_en   = 1'b0;
      model_flags = v;
   endtask

   task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [4:0] fs,
                          input logic wf, input logic [15:0] exp_res);
      int waited;
      exp_t e;
      waited   = 0;
      InValid  = 1'b1;
      InA      = a;
      InB      = b;
      InFunSel = fs;
      InWF     = wf;
      while (InReady !== 1'b1 && waited < 50) begin
         if (waited > 3) OutReady = 1'b1;
         step();
         waited++;
      end
      if (InReady !== 1'b1) begin
         check({31'b0, InReady}, 32'd1, "push_timeout");
         InValid = 1'b0;
         return;
      end
      if (wf) model_flags = flag_fn(exp_res, fs, model_flags);
      e.res   = exp_res;
      e.flags = model_flags;
      e.wf    = wf;
      exp_q.push_back(e);
      step();
      InValid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int w;
      w = 0;
      while (OutValid !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      check({31'b0, OutValid}, 32'd1, tag);
   endtask

   task automatic drain(input string tag);
      int w;
      w = 0;
      OutReady = 1'b1;
      while (exp_q.size() != 0 && w < 200) begin
         step();
         w++;
      end
      check(exp_q.size(), 32'd0, tag);
      step();
      check({31'b0, OutValid}, 32'd0, {tag, "_idle"});
`ifdef ALU_ISSUE_PERF_EN
      check({16'b0, IssueCount}, 32'(beats & 16'hFFFF), {tag, "_issue_cnt"});
      check({16'b0, StallCount}, 32'(stalls & 16'hFFFF), {tag, "_stall_cnt"});
`endif
   endtask

   initial begin
      Reset = 1'b1; InValid = 1'b0; InA = 16'h0000; InB = 16'h0000;
      InFunSel = 5'b00000; InWF = 1'b0; OutReady = 1'b0;
      preset_en = 1'b0; preset_val = 4'b0000; model_flags = 4'b0000;
      repeat (3) @(posedge Clock);
      #1;
      check({16'b0, A}, 32'd0, "rst_A");
      check({16'b0, B}, 32'd0, "rst_B");
      check({27'b0, FunSel}, 32'd0, "rst_FunSel");
      check({31'b0, WF}, 32'd0, "rst_WF");
      check({31'b0, OutValid}, 32'd0, "rst_OutValid");
      check({16'b0, OutResult}, 32'd0, "rst_OutResult");
      check({28'b0, OutFlags}, 32'd0, "rst_OutFlags");
      check({31'b0, InReady}, 32'd1, "rst_InReady");
      Reset = 1'b0;
      step();

      // single op: latency, one-cycle WF, exact result and flags
      preset(4'b1000);
      OutReady = 1'b1;
      push_op(16'hE168, 16'hBCA5, FS_AND16, 1'b1, 16'hA020);
      check({31'b0, WF}, 32'd0, "t1_wf_e0");
      step();
      check({31'b0, WF}, 32'd1, "t1_wf_issue");
      check({16'b0, A}, 32'h0000E168, "t1_A");
      check({31'b0, OutValid}, 32'd0, "t1_valid_e1");
      step();
      check({31'b0, WF}, 32'd0, "t1_wf_capture");
      check({31'b0, OutValid}, 32'd0, "t1_valid_e2");
      step();
      check({31'b0, OutValid}, 32'd1, "t1_valid_e3");
      check({16'b0, OutResult}, 32'h0000A020, "t1_result");
      check({28'b0, OutFlags}, 32'b0010, "t1_flags");
      step();
      check({31'b0, OutValid}, 32'd0, "t1_accepted");
      drain("t1_drain");

      // WF=0 keeps preset flags
      preset(4'b1101);
      push_op(16'hAA6D, 16'hAC34, FS_OR16, 1'b0, 16'hAE7D);
      wait_valid("t2_valid");
      check({16'b0, OutResult}, 32'h0000AE7D, "t2_result");
      check({28'b0, OutFlags}, 32'b1101, "t2_flags");
      drain("t2_drain");

      // back-pressure: fill FIFO plus one in flight, then hold a further push
      OutReady = 1'b0;
      push_op(16'hE168, 16'hBCA5, FS_AND16, 1'b1, 16'hA020);
      push_op(16'hAA6D, 16'hAC34, FS_OR16, 1'b1, 16'hAE7D);
      push_op(16'hABCD, 16'h0F12, FS_XOR16, 1'b1, 16'hA4DF);
      push_op(16'h1111, 16'h8888, FS_NAND16, 1'b1, 16'hFFFF);
      push_op(16'h0069, 16'h00E1, FS_AND8, 1'b1, 16'h0061);
      check({31'b0, InReady}, 32'd0, "t3_full");
      InValid = 1'b1; InA = 16'h0F0F; InB = 16'h00FF; InFunSel = FS_AND16; InWF = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check({31'b0, InReady}, 32'd0, "t3_held");
      end
      OutReady = 1'b1;
      push_op(16'h0F0F, 16'h00FF, FS_AND16, 1'b1, 16'h000F);
      drain("t3_drain");

      // simultaneous push and pop with two entries queued
      OutReady = 1'b0;
      push_op(16'h1234, 16'h00FF, FS_AND16, 1'b1, 16'h0034);
      push_op(16'h1200, 16'h0034, FS_OR16, 1'b0, 16'h1234);
      push_op(16'hFFFF, 16'hFFFF, FS_XOR16, 1'b1, 16'h0000);
      wait_valid("t4_hold");
      OutReady = 1'b1;
      push_op(16'h0001, 16'h0001, FS_NAND16, 1'b1, 16'hFFFE);
      OutReady = 1'b0;
      check({31'b0, InReady}, 32'd1, "t4_after_swap");
      push_op(16'h00F0, 16'h0080, FS_AND8, 1'b1, 16'h0080);
      check({31'b0, InReady}, 32'd1, "t4_three");
      push_op(16'h8000, 16'h0001, FS_OR16, 1'b1, 16'h8001);
      check({31'b0, InReady}, 32'd0, "t4_full");
      drain("t4_drain");

      // reset during ISSUE: flags untouched, FIFO discarded
      preset(4'b0000);
      flags_before = model_flags;
      push_op(16'hFFFF, 16'h8000, FS_AND16, 1'b1, 16'h8000);
      push_op(16'h1234, 16'h4321, FS_OR16, 1'b1, 16'h5335);
      for (int i = 0; i < 10 && WF !== 1'b1; i++) step();
      check({31'b0, WF}, 32'd1, "t5_in_issue");
      Reset = 1'b1;
      #1;
      check({31'b0, WF}, 32'd0, "t5_wf_drop");
      check({31'b0, OutValid}, 32'd0, "t5_valid_drop");
      check({31'b0, InReady}, 32'd1, "t5_inready");
      step();
      check({28'b0, alu_flags}, {28'b0, flags_before}, "t5_flags_kept");
      Reset = 1'b0;
      exp_q.delete();
      model_flags = flags_before;
`ifdef ALU_ISSUE_PERF_EN
      check({16'b0, IssueCount}, 32'd0, "t5_issue_cleared");
`endif
      step();
      check({31'b0, OutValid}, 32'd0, "t5_fifo_empty");
      push_op(16'h1234, 16'h1234, FS_XOR16, 1'b1, 16'h0000);
      wait_valid("t5_valid");
      check({28'b0, OutFlags}, 32'b1000, "t5_flags");
      drain("t5_drain");

      // randomized ops with random downstream readiness
      for (int i = 0; i < 24; i++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rfs = fs_tab[$urandom_range(0, 4)];
         rwf = 1'($urandom_range(0, 1));
         OutReady = 1'($urandom_range(0, 1));
         push_op(ra, rb, rfs, rwf, alu_fn(ra, rb, rfs));
         repeat ($urandom_range(0, 2)) step();
      end
      drain("rnd_drain");
      check(32'(wf_cycles), 32'(wf_done), "wf_pulse_count");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
